key_debounce_array: RTL and testbench

//  N-channel push-button conditioner: synchronises, debounces and edge-detects raw keys. Adds per-key

---
 rtl/key_debounce_pkg.sv | 21 ++
 rtl/key_debounce_chan.sv | 138 +++++++++++++
 rtl/key_debounce_array.sv | 61 ++++++
 tb/tb_key_debounce_array.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared state encoding and counter-width helper for the key debounce array.
package key_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } kd_state_t;

    // Width of a counter that must reach the largest of three terminal values.
    function automatic int kd_cw(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, polarity normalise, debounce/auto-repeat FSM.
// Latency: 2 sync cycles + DB_TICKS ticks to a press/release pulse; no backpressure, outputs registered.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DB_TICKS   = 250,
    parameter int REP_DELAY  = 30000,
    parameter int REP_PERIOD = 8000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    input  logic i_rep_en,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_repeat,
    output logic o_release
);

    localparam int CW = kd_cw(DB_TICKS, REP_DELAY, REP_PERIOD);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_TICKS - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REP_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    r_sync;
    kd_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_repeat;
    logic          r_release;
    logic          w_act;

    assign w_act = r_sync[1] ^ ACTIVE_LOW;

    // Sync flops reset to the released level so a key held through reset re-debounces.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= {2{ACTIVE_LOW}};
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key};
            r_press   <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_act) begin
                        r_state <= PRESS_DB;
                        r_cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!w_act) begin
                        r_state <= IDLE;
                    end else if (i_tick) begin
                        if (r_cnt == DB_LAST) begin
                            r_state <= HELD;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                HELD: begin
                    if (!w_act) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end else if (!i_rep_en) begin
                        r_cnt <= '0;
                    end else if (i_tick) begin
                        if (r_cnt == RD_LAST) begin
                            r_state  <= REPEAT;
                            r_cnt    <= '0;
                            r_press  <= 1'b1;
                            r_repeat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!w_act) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end else if (!i_rep_en) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (i_tick) begin
                        if (r_cnt == RP_LAST) begin
                            r_cnt    <= '0;
                            r_press  <= 1'b1;
                            r_repeat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                REL_DB: begin
                    // A short glitch back to pressed keeps the level and restarts the repeat delay.
                    if (w_act) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (i_tick) begin
                        if (r_cnt == DB_LAST) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_repeat  = r_repeat;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce_array.sv
// N-key conditioner: shared tick prescaler feeding one debounce/auto-repeat channel per key.
// Latency: 2 sync cycles + DB_TICKS ticks per event; no backpressure, all outputs registered.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS     = 5,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int TICK_DIV   = 1000,
    parameter int DB_TICKS   = 250,
    parameter int REP_DELAY  = 30000,
    parameter int REP_PERIOD = 8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] rep_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_repeat,
    output logic [N_KEYS-1:0] key_release
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_ONE;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW (ACTIVE_LOW),
            .DB_TICKS   (DB_TICKS),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_chan (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_key     (key_in[g]),
            .i_rep_en  (rep_en[g]),
            .i_tick    (w_tick),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_repeat  (key_repeat[g]),
            .o_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: table of hold phases plus bounce, repeat-timing and reset sequences.
module tb_key_debounce_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] rep_en;
    logic [1:0] key_level, key_press, key_repeat, key_release;

    key_debounce_array #(
        .N_KEYS(2), .ACTIVE_LOW(1'b1), .TICK_DIV(4), .DB_TICKS(3), .REP_DELAY(5), .REP_PERIOD(2)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .rep_en(rep_en),
        .key_level(key_level), .key_press(key_press), .key_repeat(key_repeat), .key_release(key_release)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event monitor: samples 3 time units after each rising edge.
    int         cyc = 0;
    int         press_cnt[2] = '{0, 0};
    int         rel_cnt[2]   = '{0, 0};
    int         rep_cnt[2]   = '{0, 0};
    int         first_p0 = -1, first_r0 = -1, last_p0 = -1, last_p1 = -2;
    int         viol = 0;
    int         press_q0[$];
    int         rep_q0[$];
    logic [1:0] prev_press = 2'b00;

    always begin
        @(posedge clk);
        #3;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (key_press[k])   press_cnt[k]++;
            if (key_release[k]) rel_cnt[k]++;
            if (key_repeat[k])  rep_cnt[k]++;
        end
        if (key_press[0]) begin
            press_q0.push_back(cyc);
            last_p0 = cyc;
            if (first_p0 < 0) first_p0 = cyc;
        end
        if (key_press[1]) last_p1 = cyc;
        if (key_repeat[0]) rep_q0.push_back(cyc);
        if (key_release[0] && first_r0 < 0) first_r0 = cyc;
        if ((key_press & key_release) != 2'b00) viol++;
        if ((key_repeat & ~key_press) != 2'b00) viol++;
        if ((key_press & prev_press) != 2'b00) viol++;
        prev_press = key_press;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    typedef struct {
        logic [1:0] key;
        logic [1:0] rep;
        int         hold;
        int         p0, p1, r0, r1, rp0;
        logic [1:0] lvl;
        int         lat;   // 1: check ch0 press latency, 2: check ch0 release latency
        bit         same;  // both channels must press in the same cycle
    } vec_t;

    vec_t tbl[9];

    initial begin
        int s, n, t0;
        int bp0, bp1, br0, br1, brp0;

        // key_in is active-low: bit 0 = pressed
        tbl[0] = '{2'b10, 2'b00, 60, 1, 0, 0, 0, 0, 2'b01, 1, 1'b0}; // press key0
        tbl[1] = '{2'b11, 2'b00, 30, 0, 0, 1, 0, 0, 2'b00, 2, 1'b0}; // release key0
        tbl[2] = '{2'b00, 2'b00, 30, 1, 1, 0, 0, 0, 2'b11, 0, 1'b1}; // both together
        tbl[3] = '{2'b10, 2'b00, 30, 0, 0, 0, 1, 0, 2'b01, 0, 1'b0}; // release key1 only
        tbl[4] = '{2'b11, 2'b00,  6, 0, 0, 0, 0, 0, 2'b01, 0, 1'b0}; // short glitch on key0
        tbl[5] = '{2'b10, 2'b00, 30, 0, 0, 0, 0, 0, 2'b01, 0, 1'b0}; // still held after glitch
        tbl[6] = '{2'b11, 2'b00, 30, 0, 0, 1, 0, 0, 2'b00, 2, 1'b0}; // release key0
        tbl[7] = '{2'b10, 2'b01, 52, 4, 0, 0, 0, 3, 2'b01, 1, 1'b0}; // press + 3 repeats
        tbl[8] = '{2'b11, 2'b01, 30, 0, 0, 1, 0, 0, 2'b00, 2, 1'b0}; // release out of REPEAT

        rst    = 1'b1;
        key_in = 2'b11;
        rep_en = 2'b00;
        cycles(2);
        chk("reset_level",   int'(key_level),   0);
        chk("reset_press",   int'(key_press),   0);
        chk("reset_repeat",  int'(key_repeat),  0);
        chk("reset_release", int'(key_release), 0);
        rst = 1'b0;
        cycles(5);

        for (int i = 0; i < 9; i++) begin
            key_in = tbl[i].key;
            rep_en = tbl[i].rep;
            s    = cyc;
            bp0  = press_cnt[0]; bp1 = press_cnt[1];
            br0  = rel_cnt[0];   br1 = rel_cnt[1];
            brp0 = rep_cnt[0];
            first_p0 = -1; first_r0 = -1; last_p0 = -1; last_p1 = -2;
            cycles(tbl[i].hold);
            chk($sformatf("row%0d_press0", i),   press_cnt[0] - bp0, tbl[i].p0);
            chk($sformatf("row%0d_press1", i),   press_cnt[1] - bp1, tbl[i].p1);
            chk($sformatf("row%0d_release0", i), rel_cnt[0] - br0,   tbl[i].r0);
            chk($sformatf("row%0d_release1", i), rel_cnt[1] - br1,   tbl[i].r1);
            chk($sformatf("row%0d_repeat0", i),  rep_cnt[0] - brp0,  tbl[i].rp0);
            chk($sformatf("row%0d_level", i),    int'(key_level),    int'(tbl[i].lvl));
            if (tbl[i].lat == 1) chk_rng($sformatf("row%0d_press_latency", i), first_p0 - s, 11, 15);
            if (tbl[i].lat == 2) chk_rng($sformatf("row%0d_release_latency", i), first_r0 - s, 11, 15);
            if (tbl[i].same) chk($sformatf("row%0d_same_cycle", i), last_p1, last_p0);
        end

        // Bounce: key0 toggles every 3 cycles, then settles pressed.
        rep_en = 2'b00;
        key_in = 2'b11;
        cycles(10);
        bp0 = press_cnt[0];
        for (int i = 0; i < 10; i++) begin
            key_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(3);
        end
        chk("bounce_no_press", press_cnt[0] - bp0, 0);
        key_in[0] = 1'b0;
        s = cyc;
        first_p0 = -1;
        cycles(30);
        chk("bounce_one_press", press_cnt[0] - bp0, 1);
        chk_rng("bounce_latency", first_p0 - s, 11, 15);
        key_in = 2'b11;
        cycles(30);

        // Repeat timing, rep_en dropped 30 cycles after the accepted press.
        press_q0.delete();
        rep_q0.delete();
        rep_en = 2'b01;
        key_in = 2'b10;
        s = cyc;
        n = 0;
        while (press_q0.size() == 0 && n < 40) begin
            cycles(1);
            n++;
        end
        chk("rep_first_press_seen", (press_q0.size() > 0) ? 1 : 0, 1);
        t0 = (press_q0.size() > 0) ? press_q0[0] : cyc;
        chk_rng("rep_press_latency", t0 - s, 11, 15);
        while (cyc < t0 + 30) cycles(1);
        rep_en = 2'b00;
        while (cyc < s + 120) cycles(1);
        key_in = 2'b11;
        cycles(30);
        chk("rep_press_count", press_q0.size(), 3);
        chk("rep_repeat_count", rep_q0.size(), 2);
        if (press_q0.size() >= 3) begin
            chk("rep_first_repeat_at", press_q0[1] - t0, 20);
            chk("rep_second_repeat_at", press_q0[2] - t0, 28);
        end
        if (rep_q0.size() >= 1) chk("rep_flag_first_at", rep_q0[0] - t0, 20);

        // Reset while a key is held: no release, fresh debounce afterwards.
        key_in = 2'b10;
        cycles(30);
        chk("rst_pre_level", int'(key_level), 1);
        br0 = rel_cnt[0];
        bp0 = press_cnt[0];
        rst = 1'b1;
        cycles(1);
        chk("rst_mid_level", int'(key_level), 0);
        chk("rst_mid_pulses", int'({key_press, key_repeat, key_release}), 0);
        cycles(1);
        rst = 1'b0;
        s = cyc;
        first_p0 = -1;
        cycles(30);
        chk("rst_no_release", rel_cnt[0] - br0, 0);
        chk("rst_repress", press_cnt[0] - bp0, 1);
        chk_rng("rst_repress_latency", first_p0 - s, 11, 15);
        chk("rst_post_level", int'(key_level), 1);
        key_in = 2'b11;
        cycles(30);

        chk("pulse_invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
